// File: rtl/stage_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_pkg : stage indices, control_op encoding and fault codes               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package seq_pkg;

   localparam int STAGE_CONTROL    = 0;
   localparam int STAGE_FETCH      = 1;
   localparam int STAGE_DECODE     = 2;
   localparam int STAGE_READ       = 3;
   localparam int STAGE_EXECUTE    = 4;
   localparam int STAGE_MEMORY     = 5;
   localparam int STAGE_WRITE_BACK = 6;
   localparam int STAGE_UPDATE_PC  = 7;

   typedef enum logic [1:0] {
      CTRL_TRAP    = 2'b00,
      CTRL_EXT_INT = 2'b01,
      CTRL_SW_INT  = 2'b10,
      CTRL_NORMAL  = 2'b11
   } control_op_e;

   localparam logic [2:0] FAULT_INSTR_MISALIGNED = 3'b000;
   localparam logic [2:0] FAULT_INSTR_ACCESS     = 3'b001;
   localparam logic [2:0] FAULT_ILLEGAL          = 3'b010;
   localparam logic [2:0] FAULT_LOAD_MISALIGNED  = 3'b100;
   localparam logic [2:0] FAULT_LOAD_ACCESS      = 3'b101;
   localparam logic [2:0] FAULT_STORE_MISALIGNED = 3'b110;
   localparam logic [2:0] FAULT_STORE_ACCESS     = 3'b111;

   function automatic control_op_e select_ctrl(input logic trap, input logic ext, input logic sw);
      if (trap) return CTRL_TRAP;
      if (ext)  return CTRL_EXT_INT;
      if (sw)   return CTRL_SW_INT;
      return CTRL_NORMAL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stage_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage_sequencer_if : fault/interrupt inputs and stage status outputs       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface stage_sequencer_if
   import seq_pkg::*;
#(
   parameter int NUM_STAGES = 8
);
   logic                  stage_ready;
   logic                  illegal_instr_fault;
   logic                  mem_addr_fault;
   logic                  mem_access_fault;
   logic                  mem_fault_is_store;
   logic                  ext_int;
   logic                  sw_int;
   logic                  halt_req;

   logic [NUM_STAGES-1:0] stage_active;
   logic                  stage_first;
   control_op_e           control_op;
   logic [2:0]            fault_num;
   logic                  fault_valid;
   logic                  instr_done;
   logic                  halted;

   modport master (
      output stage_ready, illegal_instr_fault, mem_addr_fault, mem_access_fault,
             mem_fault_is_store, ext_int, sw_int, halt_req,
      input  stage_active, stage_first, control_op, fault_num, fault_valid,
             instr_done, halted
   );

   modport slave (
      input  stage_ready, illegal_instr_fault, mem_addr_fault, mem_access_fault,
             mem_fault_is_store, ext_int, sw_int, halt_req,
      output stage_active, stage_first, control_op, fault_num, fault_valid,
             instr_done, halted
   );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer_fault_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_fault_enc : priority encoder for illegal / fetch / load-store faults   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_fault_enc
   import seq_pkg::*;
(
   input  logic       in_control_i,
   input  logic       in_fetch_i,
   input  logic       in_mem_i,
   input  logic       illegal_i,
   input  logic       addr_fault_i,
   input  logic       access_fault_i,
   input  logic       is_store_i,
   output logic       fault_hit_o,
   output logic [2:0] fault_code_o
);
   logic w_mem_any;

   assign w_mem_any = addr_fault_i | access_fault_i;

   always_comb begin
      fault_hit_o  = 1'b0;
      fault_code_o = FAULT_INSTR_MISALIGNED;
      if (illegal_i && !in_control_i) begin
         fault_hit_o  = 1'b1;
         fault_code_o = FAULT_ILLEGAL;
      end else if (in_fetch_i && w_mem_any) begin
         fault_hit_o  = 1'b1;
         fault_code_o = addr_fault_i ? FAULT_INSTR_MISALIGNED : FAULT_INSTR_ACCESS;
      end else if (in_mem_i && w_mem_any) begin
         fault_hit_o = 1'b1;
         if (addr_fault_i)
            fault_code_o = is_store_i ? FAULT_STORE_MISALIGNED : FAULT_LOAD_MISALIGNED;
         else
            fault_code_o = is_store_i ? FAULT_STORE_ACCESS : FAULT_LOAD_ACCESS;
      end
   end
endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage_sequencer : one-hot multi-cycle stage sequencer with fault redirect  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stage_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_STAGES  = 8,
   parameter int FETCH_STAGE = 1,
   parameter int MEM_STAGE   = 5,
   parameter int MIN_DWELL   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   stage_sequencer_if.slave bus
);
   localparam int                    CNT_W            = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
   localparam logic [CNT_W-1:0]      CNT_SAT          = CNT_W'(MIN_DWELL - 1);
   localparam logic [NUM_STAGES-1:0] STAGE_CONTROL_OH = NUM_STAGES'(1) << STAGE_CONTROL;

   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  stage_first_q, stage_first_d;
   logic                  trap_pending_q, trap_pending_d;
   control_op_e           control_op_q, control_op_d;
   logic [2:0]            fault_num_q, fault_num_d;
   logic                  fault_valid_q, fault_valid_d;
   logic                  instr_done_q, instr_done_d;
   logic                  halted_q, halted_d;

   logic                  in_control, in_fetch, in_mem, in_last;
   logic                  cnt_sat, halt_hold, done;
   logic                  fault_hit;
   logic [2:0]            fault_code;

   assign in_control = stage_q[STAGE_CONTROL];
   assign in_fetch   = stage_q[FETCH_STAGE];
   assign in_mem     = stage_q[MEM_STAGE];
   assign in_last    = stage_q[NUM_STAGES-1];
   assign cnt_sat    = (cnt_q == CNT_SAT);
   assign halt_hold  = in_control & bus.halt_req;
   assign done       = cnt_sat & bus.stage_ready & ~halt_hold;

   seq_fault_enc u_fault_enc (
      .in_control_i   (in_control),
      .in_fetch_i     (in_fetch),
      .in_mem_i       (in_mem),
      .illegal_i      (bus.illegal_instr_fault),
      .addr_fault_i   (bus.mem_addr_fault),
      .access_fault_i (bus.mem_access_fault),
      .is_store_i     (bus.mem_fault_is_store),
      .fault_hit_o    (fault_hit),
      .fault_code_o   (fault_code)
   );

   always_comb begin
      stage_d        = stage_q;
      cnt_d          = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
      stage_first_d  = 1'b0;
      trap_pending_d = trap_pending_q;
      control_op_d   = control_op_q;
      fault_num_d    = fault_num_q;
      fault_valid_d  = 1'b0;
      instr_done_d   = 1'b0;
      halted_d       = cnt_sat & halt_hold;

      // Parked in CONTROL: keep control_op tracking the live interrupt lines.
      if (halted_d)
         control_op_d = select_ctrl(trap_pending_q, bus.ext_int, bus.sw_int);

      if (done) begin
         cnt_d         = '0;
         stage_first_d = 1'b1;
         if (fault_hit) begin
            stage_d        = STAGE_CONTROL_OH;
            fault_num_d    = fault_code;
            fault_valid_d  = 1'b1;
            trap_pending_d = 1'b1;
            control_op_d   = select_ctrl(1'b1, bus.ext_int, bus.sw_int);
         end else begin
            stage_d = {stage_q[NUM_STAGES-2:0], stage_q[NUM_STAGES-1]};
            if (in_control)
               trap_pending_d = 1'b0;
            if (in_last) begin
               instr_done_d = 1'b1;
               control_op_d = select_ctrl(trap_pending_q, bus.ext_int, bus.sw_int);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q        <= STAGE_CONTROL_OH;
         cnt_q          <= '0;
         stage_first_q  <= 1'b1;
         trap_pending_q <= 1'b0;
         control_op_q   <= CTRL_NORMAL;
         fault_num_q    <= 3'b000;
         fault_valid_q  <= 1'b0;
         instr_done_q   <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         stage_q        <= stage_d;
         cnt_q          <= cnt_d;
         stage_first_q  <= stage_first_d;
         trap_pending_q <= trap_pending_d;
         control_op_q   <= control_op_d;
         fault_num_q    <= fault_num_d;
         fault_valid_q  <= fault_valid_d;
         instr_done_q   <= instr_done_d;
         halted_q       <= halted_d;
      end
   end

   assign bus.stage_active = stage_q;
   assign bus.stage_first  = stage_first_q;
   assign bus.control_op   = control_op_q;
   assign bus.fault_num    = fault_num_q;
   assign bus.fault_valid  = fault_valid_q;
   assign bus.instr_done   = instr_done_q;
   // Dropping halt_req releases the halt flag in the same cycle.
   assign bus.halted       = halted_q & bus.halt_req;

endmodule
`default_nettype wire
